hamming_enc_arbiter: RTL and testbench
======================================

HAMMING_ENC_ARBITER -- requirements
Module: hamming_enc_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low, ports named clk and rst.
REQ-002 Parameter ENC_LAT, default 3, legal range 1..7: cycles from request acceptance to out_valid.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 req0_valid  input  1  requester 0 presents a message.
REQ-006 req0_data  input  8  requester 0 message.
REQ-007 req0_ready  output  1  requester 0 accepted this cycle.
REQ-008 req1_valid  input  1  requester 1 presents a message.
REQ-009 req1_data  input  8  requester 1 message.
REQ-010 req1_ready  output  1  requester 1 accepted this cycle.
REQ-011 out_valid  output  1  codeword available.
REQ-012 out_data  output  12  encoded codeword.
REQ-013 out_src  output  1  index of the requester that supplied out_data.
REQ-014 out_ready  input  1  downstream consumes the codeword.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, ENC, OUT; one message in flight at a time.
REQ-017 IDLE: if any reqN_valid, the winner's reqN_ready is driven high combinationally; the other ready stays low; handshake completes on that edge.
REQ-018 On the accept edge: the winner's data and index are registered, the latency counter is loaded with ENC_LAT, and the state goes to ENC.
REQ-019 ENC: the counter decrements each cycle; the state moves to OUT so that out_valid first goes high exactly ENC_LAT cycles after the accept edge.
REQ-020 The codeword layout is d=message: out_data[2]=d0, [4]=d1, [5]=d2, [6]=d3, [8]=d4, [9]=d5, [10]=d6, [11]=d7.
REQ-021 Parity bits: [0]=d0^d1^d3^d4^d6, [1]=d0^d2^d3^d5^d6, [3]=d1^d2^d3^d7, [7]=d4^d5^d6^d7.
REQ-022 OUT: out_valid, out_data and out_src hold stable until out_valid&&out_ready; on that edge the state goes to IDLE.
REQ-023 There is no IDLE bypass: the next accept happens no earlier than the cycle after the return to IDLE, giving a minimum period of ENC_LAT+2 cycles.
REQ-024 reqN_ready is low in ENC and OUT regardless of valids; a requester whose valid drops before grant is not served.
REQ-025 out_data and out_src are zero whenever out_valid is low.

Reset
REQ-026 While rst is low, all registers clear asynchronously: state=IDLE, counter=0, out_valid=0, out_data=0, out_src=0, busy=0, last-grant=1.
REQ-027 Reset asserted mid-operation drops the in-flight message with no out_valid pulse; readies stay low while rst is low.
REQ-028 After reset release, the first arbitration SHALL favour requester 0.

Configuration
REQ-029 Macro HAMMING_RR_EN defined: round-robin arbitration; when both valids are high, grant goes to the requester not granted last; last-grant updates on every accept.
REQ-030 Macro HAMMING_RR_EN undefined: fixed priority; requester 0 always wins a tie; the last-grant register is absent.

Verification
REQ-031 req0 sends 8'hFF, ENC_LAT=3, out_ready=1 -> out_valid 3 cycles after accept, out_data=12'hF77, out_src=0.
REQ-032 req1 sends 8'h80 -> out_data=12'h888, out_src=1; req1 sends 8'h01 -> 12'h007; 8'h00 -> 12'h000.
REQ-033 Both valid continuously with HAMMING_RR_EN -> grants alternate 0,1,0,1; without the macro -> grants 0,0,0,0.
REQ-034 out_ready held low for 10 cycles in OUT -> out_valid and out_data stable for all 10, both readies low, no new accept.
REQ-035 rst pulsed low during ENC -> out_valid never asserts for that message; busy=0 immediately; the next message is encoded normally.

Source files
------------

// File: rtl/hamming_enc_arbiter.sv
// hamming_enc_arbiter: two-requester arbiter in front of a Hamming(12,8) encoder.
// One message is in flight at a time: IDLE accepts, ENC waits ENC_LAT cycles,
// OUT holds the codeword until the consumer takes it.
// Optional feature macro: HAMMING_RR_EN selects round-robin arbitration;
// without it requester 0 has fixed priority.
`timescale 1ns/1ps

module hamming_enc_arbiter #(
  parameter int ENC_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic        out_valid,
  output logic [11:0] out_data,
  output logic        out_src,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [2:0] LAT_LOAD = 3'(ENC_LAT);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic [7:0]  msg;
  logic        src_q;
  logic        gnt0;
  logic        gnt1;
  logic        accept;
  logic [11:0] codeword;

`ifdef HAMMING_RR_EN
  // last_gnt remembers who won the previous accept; 1 after reset so requester 0 wins first
  logic last_gnt;

  // Round-robin pick: a tie goes to the requester that did not win last time
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt0 = last_gnt;
      gnt1 = ~last_gnt;
    end else begin
      gnt0 = req0_valid;
      gnt1 = req1_valid;
    end
  end

  // Track the winner of every accepted request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt <= 1'b1;
    end else if (accept) begin
      last_gnt <= gnt1;
    end
  end
`else
  // Fixed priority pick: requester 0 always wins a tie
  always_comb begin
    gnt0 = req0_valid;
    gnt1 = req1_valid & ~req0_valid;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake logic; readies are gated by rst so they stay low during reset
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (rst && (req0_valid || req1_valid)) begin
          req0_ready = gnt0;
          req1_ready = gnt1;
          accept     = 1'b1;
          state_nxt  = ENC;
        end
      end
      ENC: begin
        if (cnt <= 3'd1) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winning message and run the latency counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= 3'd0;
      msg   <= 8'd0;
      src_q <= 1'b0;
    end else if (accept) begin
      msg   <= gnt1 ? req1_data : req0_data;
      src_q <= gnt1;
      cnt   <= LAT_LOAD;
    end else if (state == ENC && cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  // Hamming(12,8) codeword: data in non-power-of-two positions, even parity at 0,1,3,7
  always_comb begin
    codeword     = 12'd0;
    codeword[2]  = msg[0];
    codeword[4]  = msg[1];
    codeword[5]  = msg[2];
    codeword[6]  = msg[3];
    codeword[8]  = msg[4];
    codeword[9]  = msg[5];
    codeword[10] = msg[6];
    codeword[11] = msg[7];
    codeword[0]  = msg[0] ^ msg[1] ^ msg[3] ^ msg[4] ^ msg[6];
    codeword[1]  = msg[0] ^ msg[2] ^ msg[3] ^ msg[5] ^ msg[6];
    codeword[3]  = msg[1] ^ msg[2] ^ msg[3] ^ msg[7];
    codeword[7]  = msg[4] ^ msg[5] ^ msg[6] ^ msg[7];
  end

  // Output side: data and source are forced to zero outside OUT
  always_comb begin
    out_valid = (state == OUT);
    out_data  = out_valid ? codeword : 12'd0;
    out_src   = out_valid & src_q;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// tb_hamming_enc_arbiter: randomized and directed checks of hamming_enc_arbiter
// against a behavioural model (generic Hamming position rule plus an arbitration model).
`timescale 1ns/1ps

module tb_hamming_enc_arbiter;

  localparam int ENC_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0;
  logic [7:0]  req0_data = 8'd0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [7:0]  req1_data = 8'd0;
  logic        req1_ready;
  logic        out_valid;
  logic [11:0] out_data;
  logic        out_src;
  logic        out_ready = 1'b1;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int model_last = 1;

`ifdef HAMMING_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  hamming_enc_arbiter #(.ENC_LAT(ENC_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Generic Hamming rule: 1-indexed positions that are powers of two hold parity
  // over every other position sharing that bit; data fills the rest in order.
  function automatic logic [11:0] model_encode(input logic [7:0] d);
    logic [11:0] cw;
    logic        par;
    int          k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = d[k];
        k++;
      end
    end
    for (int p = 1; p <= 8; p = p * 2) begin
      par = 1'b0;
      for (int pos = 1; pos <= 12; pos++) begin
        if ((pos & p) != 0 && pos != p) par ^= cw[pos-1];
      end
      cw[p-1] = par;
    end
    return cw;
  endfunction

  // Expected winner for a given pair of valids; -1 means nobody is served
  function automatic int model_pick(input logic v0, input logic v1);
    int g;
    if (v0 && v1) g = RR ? ((model_last == 1) ? 0 : 1) : 0;
    else if (v0)  g = 0;
    else if (v1)  g = 1;
    else          g = -1;
    if (g >= 0) model_last = g;
    return g;
  endfunction

  // Reset sequence; leaves the bench at posedge+1 with the DUT in IDLE
  task automatic do_reset();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_last = 1;
  endtask

  // Drive one request and collect what the DUT did (no comparisons here).
  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic send(input logic v0, input logic v1, input logic [7:0] a, input logic [7:0] b,
                      input int stall, output int gnt, output int lat,
                      output logic [11:0] data, output logic src);
    req0_valid = v0;
    req1_valid = v1;
    req0_data  = a;
    req1_data  = b;
    out_ready  = (stall == 0);
    #1;
    if (req0_ready && req1_ready) gnt = 2;
    else if (req0_ready)          gnt = 0;
    else if (req1_ready)          gnt = 1;
    else                          gnt = -1;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat  = 0;
    data = '0;
    src  = 1'b0;
    if (gnt < 0) begin
      lat = -1;
      return;
    end
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    data = out_data;
    src  = out_src;
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2;
    checks++;
    if ({out_valid, out_data, out_src, busy} !== 15'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got valid=%0b data=%h src=%0b busy=%0b, want all zero",
               out_valid, out_data, out_src, busy);
    end
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_readies: got %b, want 00", {req0_ready, req1_ready});
    end
    do_reset();
  endtask

  task automatic test_vectors();
    logic [7:0]  msgs [4] = '{8'hFF, 8'h80, 8'h01, 8'h00};
    logic [11:0] cws  [4] = '{12'hF77, 12'h888, 12'h007, 12'h000};
    int gnt, lat, exp;
    logic [11:0] data;
    logic src;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        exp = model_pick(1'b1, 1'b0);
        send(1'b1, 1'b0, msgs[i], 8'h00, 0, gnt, lat, data, src);
      end else begin
        exp = model_pick(1'b0, 1'b1);
        send(1'b0, 1'b1, 8'h00, msgs[i], 0, gnt, lat, data, src);
      end
      checks++;
      if (gnt !== exp || lat !== ENC_LAT) begin
        failures++;
        $display("[TB] FAIL vec%0d_grant_latency: got grant=%0d lat=%0d, want grant=%0d lat=%0d",
                 i, gnt, lat, exp, ENC_LAT);
      end
      checks++;
      if (data !== cws[i] || src !== exp[0]) begin
        failures++;
        $display("[TB] FAIL vec%0d_codeword: got data=%h src=%0b, want data=%h src=%0b",
                 i, data, src, cws[i], exp[0]);
      end
    end
  endtask

  task automatic test_arbitration();
    int gnt, lat, exp;
    logic [11:0] data;
    logic src;
    logic [7:0] a, b;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      exp = RR ? (i % 2) : 0;
      void'(model_pick(1'b1, 1'b1));
      send(1'b1, 1'b1, a, b, 0, gnt, lat, data, src);
      checks++;
      if (gnt !== exp) begin
        failures++;
        $display("[TB] FAIL arb_grant%0d: got %0d, want %0d", i, gnt, exp);
      end
      checks++;
      if (data !== model_encode(exp == 1 ? b : a) || src !== exp[0]) begin
        failures++;
        $display("[TB] FAIL arb_data%0d: got data=%h src=%0b, want data=%h src=%0b",
                 i, data, src, model_encode(exp == 1 ? b : a), exp[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  a;
    logic [11:0] exp_cw;
    int lat, exp;
    a = 8'($urandom);
    exp_cw = model_encode(a);
    exp = model_pick(1'b1, 1'b0);
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    req0_data  = a;
    out_ready  = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10 || exp !== 0) begin
      failures++;
      $display("[TB] FAIL bp_accept: got readies=%b, want 10", {req0_ready, req1_ready});
    end
    @(posedge clk);
    #1;
    req1_valid = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== ENC_LAT) begin
      failures++;
      $display("[TB] FAIL bp_latency: got %0d, want %0d", lat, ENC_LAT);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({out_valid, out_data, out_src, req0_ready, req1_ready} !== {1'b1, exp_cw, 1'b0, 2'b00}) begin
        failures++;
        $display("[TB] FAIL bp_hold%0d: got valid=%0b data=%h src=%0b rdy=%b, want valid=1 data=%h src=0 rdy=00",
                 i, out_valid, out_data, out_src, {req0_ready, req1_ready}, exp_cw);
      end
      @(posedge clk);
      #1;
    end
    out_ready  = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, busy} !== 14'd0) begin
      failures++;
      $display("[TB] FAIL bp_release: got valid=%0b data=%h busy=%0b, want all zero",
               out_valid, out_data, busy);
    end
  endtask

  task automatic test_reset_mid();
    int gnt, lat, exp, seen;
    logic [11:0] data;
    logic src;
    logic [7:0] a;
    do_reset();
    req1_valid = 1'b1;
    req1_data  = 8'($urandom);
    #1;
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if ({busy, out_valid, req0_ready, req1_ready} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL midreset_state: got busy=%0b valid=%0b rdy=%b, want 0 0 00",
               busy, out_valid, {req0_ready, req1_ready});
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    model_last = 1;
    seen = 0;
    for (int i = 0; i < ENC_LAT + 3; i++) begin
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("[TB] FAIL midreset_no_output: got %0d valid cycles, want 0", seen);
    end
    a = 8'($urandom);
    exp = model_pick(1'b1, 1'b1);
    send(1'b1, 1'b1, a, 8'($urandom), 0, gnt, lat, data, src);
    checks++;
    if (gnt !== exp || exp !== 0 || lat !== ENC_LAT || data !== model_encode(a) || src !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_next: got grant=%0d lat=%0d data=%h src=%0b, want grant=0 lat=%0d data=%h src=0",
               gnt, lat, data, src, ENC_LAT, model_encode(a));
    end
  endtask

  task automatic test_random();
    int gnt, lat, exp;
    logic [11:0] data, exp_cw;
    logic src, v0, v1;
    logic [7:0] a, b;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      a  = 8'($urandom);
      b  = 8'($urandom);
      exp = model_pick(v0, v1);
      send(v0, v1, a, b, $urandom_range(0, 3), gnt, lat, data, src);
      checks++;
      if (gnt !== exp) begin
        failures++;
        $display("[TB] FAIL rand%0d_grant: got %0d, want %0d (v0=%0b v1=%0b)", i, gnt, exp, v0, v1);
      end
      if (exp >= 0) begin
        exp_cw = model_encode(exp == 1 ? b : a);
        checks++;
        if (lat !== ENC_LAT || data !== exp_cw || src !== exp[0]) begin
          failures++;
          $display("[TB] FAIL rand%0d_output: got lat=%0d data=%h src=%0b, want lat=%0d data=%h src=%0b",
                   i, lat, data, src, ENC_LAT, exp_cw, exp[0]);
        end
      end
      checks++;
      if ({busy, out_valid, out_data, out_src} !== 15'd0) begin
        failures++;
        $display("[TB] FAIL rand%0d_idle: got busy=%0b valid=%0b data=%h src=%0b, want all zero",
                 i, busy, out_valid, out_data, out_src);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
